writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage of the 64-bit RISC-V core. It accepts completed instructions from the memory stage over a valid/ready handshake, and formats load data (byte/half/word/double, signed/unsigned, byte offset). It drives the register file write port and holds each write until the register file acknowledges it with write_complete. On acknowledge it releases the destination register to the decode-stage hazard logic and counts retired instructions.

## Interface
- DATA_WIDTH, 64, datapath and register width
- ADDR_WIDTH, 5, register index width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_wen  in  1  instruction writes rd
- in_rd  in  ADDR_WIDTH  destination register
- in_is_load  in  1  result comes from memory data
- in_funct3  in  3  load size/sign encoding
- in_addr_lo  in  3  low bits of load byte address
- in_alu_result  in  DATA_WIDTH  non-load result
- in_mem_data  in  DATA_WIDTH  aligned 64-bit memory doubleword
- rf_write_enable  out  1  register file write strobe
- rf_write_addr  out  ADDR_WIDTH  register file write index
- rf_write_data  out  DATA_WIDTH  register file write value
- rf_write_complete  in  1  register file write acknowledge (registered, one cycle after strobe)
- clear_valid  out  1  one-cycle release pulse to hazard logic
- clear_addr  out  ADDR_WIDTH  register being released
- load_fault  out  1  one-cycle misaligned/illegal load pulse
- fault_rd  out  ADDR_WIDTH  rd of faulting load
- retire_count  out  64  retired instruction counter

## Operation
- FSM states: IDLE, WRITE, WAIT_ACK.
- in_ready = !reset && (IDLE || (WAIT_ACK && rf_write_complete)).
- Acceptance when in_valid && in_ready.
- Writing acceptance (in_wen, in_rd != 0, no fault):
  - capture rd and the formatted result, then go to WRITE.
  - rf_write_enable is high for exactly one cycle in WRITE, then the FSM goes to WAIT_ACK.
- WAIT_ACK with rf_write_complete:
  - pulse clear_valid/clear_addr = held rd and increment retire_count.
  - then go to IDLE, or to WRITE if a new writing instruction is accepted in the same cycle.
- Non-writing acceptance (in_wen=0 or in_rd=0):
  - no register file access.
  - retire_count increments the next cycle; the FSM stays in or returns to IDLE.
- Load formatting: shift in_mem_data right by in_addr_lo*8, then select by funct3:
  - 000 LB, 001 LH, 010 LW: sign-extend.
  - 011 LD: full doubleword.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
- Fault conditions:
  - funct3 111.
  - LH/LHU with odd offset.
  - LW/LWU with offset[1:0] != 0.
  - LD with offset != 0.
- On fault: no write, no clear_valid; next cycle load_fault pulses with fault_rd; retire_count still increments.
- retire_count wraps modulo 2^64.

## Timing
- Reset values:
  - state IDLE, in_ready 0 during reset.
  - rf_write_enable 0, rf_write_addr 0, rf_write_data 0.
  - clear_valid 0, clear_addr 0, load_fault 0, fault_rd 0, retire_count 0.
- Reset mid-operation discards the held entry; no clear_valid is issued.
- Latency:
  - accept at cycle N, write strobe at N+1, ack at N+2, clear_valid at N+2 (combinational from ack, registered address).
  - retire_count visible at N+3.
- Sustained throughput: one writing instruction per 2 cycles; non-writing instructions 1 per cycle in IDLE.
- All outputs except in_ready and clear_valid are registered.
- rf_write_complete outside WAIT_ACK is ignored.

## Structure
- Package wb_pkg: funct3 load encodings (LB…LWU), state enum, fault-check function.
- Sub-module load_formatter: combinational shift/extend plus fault detect; instantiated once.

## Test plan
- ALU write:
  - Stimulus: rd=5, result 0x1234, ack one cycle after strobe.
  - Required: strobe at N+1 with addr 5 / data 0x1234, clear_valid addr 5 at N+2, retire_count=1.
- LB:
  - Stimulus: offset 3, mem 0x00000000_80000000.
  - Required: write 0xFFFFFFFF_FFFFFF80. Same stimulus as LBU writes 0x80.
- LW:
  - Stimulus: offset 2.
  - Required: load_fault pulse with fault_rd, no rf_write_enable, retire_count increments.
- Stall:
  - Stimulus: withhold rf_write_complete 4 cycles.
  - Required: in_ready low throughout, rf_write_enable single cycle, no clear_valid until ack.
- Back-to-back:
  - Stimulus: writes rd=1, rd=2 with continuous in_valid.
  - Required: second accepted in the ack cycle of the first, strobes 2 cycles apart.
- Reset:
  - Stimulus: assert reset in WAIT_ACK.
  - Required: all outputs return to reset values, no clear_valid, retire_count=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: load funct3 codes, FSM states
// and the load alignment / legality check.
package wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WAIT_ACK = 2'd2
  } wb_state_e;

  // High when a load of this size cannot be taken from this byte offset.
  function automatic logic load_fault_check(input logic [2:0] funct3,
                                            input logic [2:0] offset);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = offset[0];
      F3_LW, F3_LWU: bad = (offset[1:0] != 2'b00);
      F3_LD:         bad = (offset != 3'b000);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// Combinational result select: aligns and extends load data, or passes the
// ALU result through, and flags illegal/misaligned loads.
module load_formatter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  is_load,
  input  logic [2:0]            funct3,
  input  logic [2:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  fault
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_val;

  assign shifted = mem_data >> {addr_lo, 3'b000};

  always_comb begin
    load_val = shifted;
    case (funct3)
      F3_LB:  load_val = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_LH:  load_val = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_LW:  load_val = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
      F3_LD:  load_val = shifted;
      F3_LBU: load_val = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      F3_LHU: load_val = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      F3_LWU: load_val = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  assign result = is_load ? load_val : alu_result;
  assign fault  = is_load && load_fault_check(funct3, addr_lo);

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: accepts completed instructions, writes the register
// file, waits for its acknowledge, then releases rd and counts retirement.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wen,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [2:0]            in_addr_lo,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_mem_data,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  input  logic                  rf_write_complete,
  output logic                  clear_valid,
  output logic [ADDR_WIDTH-1:0] clear_addr,
  output logic                  load_fault,
  output logic [ADDR_WIDTH-1:0] fault_rd,
  output logic [63:0]           retire_count
);

  wb_state_e             state_q, state_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  fault_q, fault_d;
  logic [ADDR_WIDTH-1:0] fault_rd_q, fault_rd_d;
  logic [63:0]           retire_q, retire_d;

  logic [DATA_WIDTH-1:0] fmt_result;
  logic                  fmt_fault;
  logic                  accept;
  logic                  ack;
  logic                  writing;
  logic                  non_writing;

  load_formatter #(.DATA_WIDTH(DATA_WIDTH)) u_fmt (
    .is_load    (in_is_load),
    .funct3     (in_funct3),
    .addr_lo    (in_addr_lo),
    .alu_result (in_alu_result),
    .mem_data   (in_mem_data),
    .result     (fmt_result),
    .fault      (fmt_fault)
  );

  // Acknowledges only count while a write is outstanding.
  assign ack         = !reset && (state_q == WAIT_ACK) && rf_write_complete;
  assign in_ready    = !reset && ((state_q == IDLE) || ack);
  assign accept      = in_valid && in_ready;
  assign writing     = accept && in_wen && (in_rd != '0) && !fmt_fault;
  assign non_writing = accept && !writing;

  always_comb begin
    state_d    = state_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    fault_d    = accept && fmt_fault;
    fault_rd_d = fault_rd_q;
    retire_d   = retire_q + 64'(ack) + 64'(non_writing);

    case (state_q)
      IDLE:     if (writing) state_d = WRITE;
      WRITE:    state_d = WAIT_ACK;
      WAIT_ACK: if (ack) state_d = writing ? WRITE : IDLE;
      default:  state_d = IDLE;
    endcase

    if (writing) begin
      wen_d   = 1'b1;
      waddr_d = in_rd;
      wdata_d = fmt_result;
    end
    if (accept && fmt_fault) fault_rd_d = in_rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      fault_q    <= 1'b0;
      fault_rd_q <= '0;
      retire_q   <= '0;
    end else begin
      state_q    <= state_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      fault_q    <= fault_d;
      fault_rd_q <= fault_rd_d;
      retire_q   <= retire_d;
    end
  end

  assign rf_write_enable = wen_q;
  assign rf_write_addr   = waddr_q;
  assign rf_write_data   = wdata_q;
  // The held write address doubles as the released register.
  assign clear_valid     = ack;
  assign clear_addr      = waddr_q;
  assign load_fault      = fault_q;
  assign fault_rd        = fault_rd_q;
  assign retire_count    = retire_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed-vector bench for writeback_stage with hand-computed expectations.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [4:0]  in_rd;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [2:0]  in_addr_lo;
  logic [63:0] in_alu_result;
  logic [63:0] in_mem_data;
  logic        rf_write_enable;
  logic [4:0]  rf_write_addr;
  logic [63:0] rf_write_data;
  logic        rf_write_complete;
  logic        clear_valid;
  logic [4:0]  clear_addr;
  logic        load_fault;
  logic [4:0]  fault_rd;
  logic [63:0] retire_count;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] exp_ret = 64'd0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_wen            (in_wen),
    .in_rd             (in_rd),
    .in_is_load        (in_is_load),
    .in_funct3         (in_funct3),
    .in_addr_lo        (in_addr_lo),
    .in_alu_result     (in_alu_result),
    .in_mem_data       (in_mem_data),
    .rf_write_enable   (rf_write_enable),
    .rf_write_addr     (rf_write_addr),
    .rf_write_data     (rf_write_data),
    .rf_write_complete (rf_write_complete),
    .clear_valid       (clear_valid),
    .clear_addr        (clear_addr),
    .load_fault        (load_fault),
    .fault_rd          (fault_rd),
    .retire_count      (retire_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wen, input logic [4:0] rd, input logic is_load,
                       input logic [2:0] f3, input logic [2:0] off,
                       input logic [63:0] alu, input logic [63:0] mem);
    in_valid      = 1'b1;
    in_wen        = wen;
    in_rd         = rd;
    in_is_load    = is_load;
    in_funct3     = f3;
    in_addr_lo    = off;
    in_alu_result = alu;
    in_mem_data   = mem;
  endtask

  // Full write with an ack one cycle after the strobe.
  task automatic write_vec(input string tag, input logic [4:0] rd, input logic is_load,
                           input logic [2:0] f3, input logic [2:0] off,
                           input logic [63:0] alu, input logic [63:0] mem,
                           input logic [63:0] exp_data);
    drive(1'b1, rd, is_load, f3, off, alu, mem);
    #1 chk({tag, "_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    #1;
    chk({tag, "_wen"}, rf_write_enable, 1);
    chk({tag, "_waddr"}, rf_write_addr, rd);
    chk({tag, "_wdata"}, rf_write_data, exp_data);
    chk({tag, "_busy"}, in_ready, 0);
    step();
    rf_write_complete = 1'b1;
    #1;
    chk({tag, "_clr"}, clear_valid, 1);
    chk({tag, "_clraddr"}, clear_addr, rd);
    chk({tag, "_wen_off"}, rf_write_enable, 0);
    step();
    rf_write_complete = 1'b0;
    exp_ret++;
    #1;
    chk({tag, "_retire"}, retire_count, exp_ret);
    chk({tag, "_clr_off"}, clear_valid, 0);
    $display("vector %s rd=%0d data=%h retire=%0d", tag, rd, exp_data, retire_count);
  endtask

  task automatic fault_vec(input string tag, input logic [4:0] rd,
                           input logic [2:0] f3, input logic [2:0] off);
    drive(1'b1, rd, 1'b1, f3, off, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    #1 chk({tag, "_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    exp_ret++;
    #1;
    chk({tag, "_lf"}, load_fault, 1);
    chk({tag, "_frd"}, fault_rd, rd);
    chk({tag, "_nowen"}, rf_write_enable, 0);
    chk({tag, "_noclr"}, clear_valid, 0);
    chk({tag, "_retire"}, retire_count, exp_ret);
    step();
    #1;
    chk({tag, "_lf_off"}, load_fault, 0);
    chk({tag, "_nowen2"}, rf_write_enable, 0);
    $display("vector %s fault rd=%0d retire=%0d", tag, rd, retire_count);
  endtask

  initial begin
    reset = 1'b1;
    rf_write_complete = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0);
    in_valid = 1'b0;
    step();
    step();
    chk("rst_ready", in_ready, 0);
    chk("rst_wen", rf_write_enable, 0);
    chk("rst_waddr", rf_write_addr, 0);
    chk("rst_wdata", rf_write_data, 0);
    chk("rst_clr", clear_valid, 0);
    chk("rst_clraddr", clear_addr, 0);
    chk("rst_lf", load_fault, 0);
    chk("rst_frd", fault_rd, 0);
    chk("rst_retire", retire_count, 0);
    $display("vector reset retire=%0d", retire_count);
    reset = 1'b0;
    step();

    write_vec("alu",  5'd5,  1'b0, 3'b000, 3'd0, 64'h1234, 64'd0, 64'h1234);
    write_vec("lb",   5'd6,  1'b1, 3'b000, 3'd3, 64'd0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    write_vec("lbu",  5'd6,  1'b1, 3'b100, 3'd3, 64'd0, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
    write_vec("lh",   5'd8,  1'b1, 3'b001, 3'd2, 64'd0, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
    write_vec("lhu",  5'd8,  1'b1, 3'b101, 3'd6, 64'd0, 64'h9ABC_0000_0000_0000, 64'h0000_0000_0000_9ABC);
    write_vec("lw",   5'd10, 1'b1, 3'b010, 3'd4, 64'd0, 64'hDEAD_BEEF_0000_0000, 64'hFFFF_FFFF_DEAD_BEEF);
    write_vec("lwu",  5'd10, 1'b1, 3'b110, 3'd4, 64'd0, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF);
    write_vec("ld",   5'd31, 1'b1, 3'b011, 3'd0, 64'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

    fault_vec("lw_off2", 5'd7,  3'b010, 3'd2);
    fault_vec("f3_111",  5'd12, 3'b111, 3'd0);
    fault_vec("lh_odd",  5'd13, 3'b001, 3'd1);
    fault_vec("ld_off4", 5'd14, 3'b011, 3'd4);

    // Non-writing instructions retire one per cycle in IDLE.
    drive(1'b1, 5'd0, 1'b0, 3'd0, 3'd0, 64'h55, 64'd0);
    step();
    drive(1'b0, 5'd9, 1'b0, 3'd0, 3'd0, 64'h55, 64'd0);
    exp_ret++;
    #1 chk("nw_rd0_retire", retire_count, exp_ret);
    chk("nw_rd0_nowen", rf_write_enable, 0);
    chk("nw_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    exp_ret++;
    #1 chk("nw_wen0_retire", retire_count, exp_ret);
    chk("nw_wen0_nowen", rf_write_enable, 0);
    $display("vector nonwrite retire=%0d", retire_count);

    // Ack while idle must be ignored.
    rf_write_complete = 1'b1;
    #1 chk("idle_ack_clr", clear_valid, 0);
    step();
    rf_write_complete = 1'b0;
    #1 chk("idle_ack_retire", retire_count, exp_ret);
    $display("vector idle_ack retire=%0d", retire_count);

    // Stall: ack withheld for 4 cycles.
    drive(1'b1, 5'd9, 1'b0, 3'd0, 3'd0, 64'hCAFE, 64'd0);
    step();
    in_valid = 1'b0;
    #1 chk("stall_wen", rf_write_enable, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("stall_ready_%0d", i), in_ready, 0);
      chk($sformatf("stall_wen_%0d", i), rf_write_enable, 0);
      chk($sformatf("stall_clr_%0d", i), clear_valid, 0);
    end
    rf_write_complete = 1'b1;
    #1 chk("stall_clr", clear_valid, 1);
    chk("stall_clraddr", clear_addr, 9);
    step();
    rf_write_complete = 1'b0;
    exp_ret++;
    #1 chk("stall_retire", retire_count, exp_ret);
    $display("vector stall rd=9 retire=%0d", retire_count);

    // Back-to-back writes rd=1 then rd=2 with in_valid held.
    drive(1'b1, 5'd1, 1'b0, 3'd0, 3'd0, 64'h11, 64'd0);
    step();
    drive(1'b1, 5'd2, 1'b0, 3'd0, 3'd0, 64'h22, 64'd0);
    #1 chk("b2b_wen1", rf_write_enable, 1);
    chk("b2b_waddr1", rf_write_addr, 1);
    chk("b2b_notready", in_ready, 0);
    step();
    rf_write_complete = 1'b1;
    #1 chk("b2b_ready_ack", in_ready, 1);
    chk("b2b_clr1", clear_valid, 1);
    chk("b2b_clraddr1", clear_addr, 1);
    chk("b2b_gap", rf_write_enable, 0);
    step();
    in_valid = 1'b0;
    rf_write_complete = 1'b0;
    exp_ret++;
    #1 chk("b2b_wen2", rf_write_enable, 1);
    chk("b2b_waddr2", rf_write_addr, 2);
    chk("b2b_wdata2", rf_write_data, 64'h22);
    chk("b2b_retire1", retire_count, exp_ret);
    step();
    rf_write_complete = 1'b1;
    #1 chk("b2b_clr2", clear_valid, 1);
    chk("b2b_clraddr2", clear_addr, 2);
    step();
    rf_write_complete = 1'b0;
    exp_ret++;
    #1 chk("b2b_retire2", retire_count, exp_ret);
    $display("vector back2back retire=%0d", retire_count);

    // Reset while waiting for ack.
    drive(1'b1, 5'd3, 1'b0, 3'd0, 3'd0, 64'h33, 64'd0);
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    rf_write_complete = 1'b1;
    #1 chk("mid_rst_clr", clear_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    step();
    rf_write_complete = 1'b0;
    #1;
    chk("mid_rst_wen", rf_write_enable, 0);
    chk("mid_rst_waddr", rf_write_addr, 0);
    chk("mid_rst_wdata", rf_write_data, 0);
    chk("mid_rst_clraddr", clear_addr, 0);
    chk("mid_rst_lf", load_fault, 0);
    chk("mid_rst_frd", fault_rd, 0);
    chk("mid_rst_retire", retire_count, 0);
    reset = 1'b0;
    exp_ret = 64'd0;
    step();
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_clr", clear_valid, 0);
    $display("vector mid_reset retire=%0d", retire_count);

    write_vec("post_rst", 5'd4, 1'b0, 3'd0, 3'd0, 64'hABCD, 64'd0, 64'hABCD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
